// File: rtl/display_timing_gen.sv
// VGA-style raster timing generator: pixel-rate divider, h/v scan counters, and a
// one-pixel output stage that keeps colour and syncs aligned at the DAC pins.
module display_timing_gen #(
   parameter int DIV     = 4,
   parameter int H_TOTAL = 800,
   parameter int H_SYNC  = 96,
   parameter int H_START = 144,
   parameter int H_END   = 783,
   parameter int V_TOTAL = 525,
   parameter int V_SYNC  = 2,
   parameter int V_START = 35,
   parameter int V_END   = 514
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] rgb,
   output logic [9:0]  hCount,
   output logic [9:0]  vCount,
   output logic        bright,
   output logic        pix_en,
   output logic        frame_tick,
   output logic        hSync,
   output logic        vSync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b
);

   localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_SYNC_C = 10'(H_SYNC);
   localparam logic [9:0]    V_SYNC_C = 10'(V_SYNC);
   localparam logic [9:0]    H_BEG_C  = 10'(H_START);
   localparam logic [9:0]    H_END_C  = 10'(H_END);
   localparam logic [9:0]    V_BEG_C  = 10'(V_START);
   localparam logic [9:0]    V_END_C  = 10'(V_END);

   logic [DW-1:0] div_cnt;
   logic          h_last;
   logic          v_last;

   assign pix_en     = (div_cnt == DIV_LAST);
   assign h_last     = (hCount == H_LAST);
   assign v_last     = (vCount == V_LAST);
   assign frame_tick = pix_en & h_last & v_last;
   assign bright     = (hCount >= H_BEG_C) && (hCount <= H_END_C) &&
                       (vCount >= V_BEG_C) && (vCount <= V_END_C);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (pix_en) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hCount <= '0;
         vCount <= '0;
      end else if (pix_en) begin
         if (h_last) begin
            hCount <= '0;
            vCount <= v_last ? 10'd0 : vCount + 10'd1;
         end else begin
            hCount <= hCount + 10'd1;
         end
      end
   end

   // Output stage samples the current pixel, so everything at the pins lags the
   // counters by one pixel period while staying mutually aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hSync <= 1'b1;
         vSync <= 1'b1;
         vga_r <= '0;
         vga_g <= '0;
         vga_b <= '0;
      end else if (pix_en) begin
         hSync                 <= ~(hCount < H_SYNC_C);
         vSync                 <= ~(vCount < V_SYNC_C);
         {vga_r, vga_g, vga_b} <= bright ? rgb : 12'h000;
      end
   end

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: default-timing instance for line-level checks and a
// shrunken-raster instance tracked every cycle by a pixel-index model and scoreboard.
module tb_display_timing_gen;

   localparam int SDIV   = 2;
   localparam int SHT    = 16;
   localparam int SHS    = 3;
   localparam int SHB    = 5;
   localparam int SHE    = 12;
   localparam int SVT    = 8;
   localparam int SVS    = 2;
   localparam int SVB    = 3;
   localparam int SVE    = 6;
   localparam int SFRAME = SHT * SVT * SDIV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] rgb;

   logic [9:0] d_hcount, d_vcount, s_hcount, s_vcount;
   logic       d_bright, d_pix_en, d_frame_tick, d_hsync, d_vsync;
   logic       s_bright, s_pix_en, s_frame_tick, s_hsync, s_vsync;
   logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;

   always #5 clk = ~clk;

   display_timing_gen dut_d (
      .clk(clk), .rst_n(rst_n), .rgb(rgb),
      .hCount(d_hcount), .vCount(d_vcount), .bright(d_bright),
      .pix_en(d_pix_en), .frame_tick(d_frame_tick),
      .hSync(d_hsync), .vSync(d_vsync),
      .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
   );

   display_timing_gen #(
      .DIV(SDIV), .H_TOTAL(SHT), .H_SYNC(SHS), .H_START(SHB), .H_END(SHE),
      .V_TOTAL(SVT), .V_SYNC(SVS), .V_START(SVB), .V_END(SVE)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .rgb(rgb),
      .hCount(s_hcount), .vCount(s_vcount), .bright(s_bright),
      .pix_en(s_pix_en), .frame_tick(s_frame_tick),
      .hSync(s_hsync), .vSync(s_vsync),
      .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit vis(input int h, input int v);
      return (h >= SHB) && (h <= SHE) && (v >= SVB) && (v <= SVE);
   endfunction

   // Model of the small instance: position is derived from the pixel index
   // elapsed since reset release; registered outputs go through a scoreboard.
   typedef struct packed {
      logic [11:0] colour;
      logic        hs;
      logic        vs;
   } reg_t;

   reg_t sb[$];
   reg_t exp_reg = '{colour: 12'h000, hs: 1'b1, vs: 1'b1};
   int   s_pix = 0;
   int   s_div = 0;
   int   mh, mv, ch, cv;
   bit   cp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_pix   = 0;
         s_div   = 0;
         sb.delete();
         exp_reg = '{colour: 12'h000, hs: 1'b1, vs: 1'b1};
      end else if (s_div == SDIV - 1) begin
         mh = s_pix % SHT;
         mv = (s_pix / SHT) % SVT;
         sb.push_back('{colour: vis(mh, mv) ? rgb : 12'h000, hs: (mh >= SHS), vs: (mv >= SVS)});
         s_pix++;
         s_div = 0;
      end else begin
         s_div++;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         ch = s_pix % SHT;
         cv = (s_pix / SHT) % SVT;
         cp = (s_div == SDIV - 1);
         check("s_hCount", s_hcount, ch);
         check("s_vCount", s_vcount, cv);
         check("s_pix_en", s_pix_en, cp);
         check("s_frame_tick", s_frame_tick, cp && ch == SHT - 1 && cv == SVT - 1);
         check("s_bright", s_bright, vis(ch, cv));
         if (sb.size() > 0) exp_reg = sb.pop_front();
         check("s_colour", {s_r, s_g, s_b}, exp_reg.colour);
         check("s_hSync", s_hsync, exp_reg.hs);
         check("s_vSync", s_vsync, exp_reg.vs);
      end
   end

   task automatic check_reset(input string tag);
      check({tag, " d_hCount"}, d_hcount, 0);
      check({tag, " d_vCount"}, d_vcount, 0);
      check({tag, " d_pix_en"}, d_pix_en, 0);
      check({tag, " d_frame_tick"}, d_frame_tick, 0);
      check({tag, " d_hSync"}, d_hsync, 1);
      check({tag, " d_vSync"}, d_vsync, 1);
      check({tag, " d_colour"}, {d_r, d_g, d_b}, 0);
      check({tag, " s_hCount"}, s_hcount, 0);
      check({tag, " s_vCount"}, s_vcount, 0);
      check({tag, " s_pix_en"}, s_pix_en, 0);
      check({tag, " s_frame_tick"}, s_frame_tick, 0);
      check({tag, " s_hSync"}, s_hsync, 1);
      check({tag, " s_vSync"}, s_vsync, 1);
      check({tag, " s_colour"}, {s_r, s_g, s_b}, 0);
   endtask

   // Advance (sampling #1 after each edge) to the first clk of pixel (h,v).
   task automatic wait_pos(input int h, input int v);
      int n = 0;
      while (!(s_hcount == 10'(h) && s_vcount == 10'(v) && !s_pix_en) && n < 2 * SFRAME) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("wait_pos reached", (n < 2 * SFRAME), 1);
   endtask

   typedef struct {
      int  edge_n;
      bit  pix_en;
      int  h;
   } dvec_t;

   typedef struct {
      int          h;
      int          v;
      logic [11:0] rgb;
      bit          bright;
      logic [11:0] colour;
      bit          hs;
      bit          vs;
   } svec_t;

   dvec_t dt[8];
   svec_t st[10];
   int    pe_cnt, hs_low, first_low, col_bad, ft_cnt, vis_cnt, vs_low;

   initial begin
      dt[0] = '{1, 0, 0};  dt[1] = '{2, 0, 0};  dt[2] = '{3, 1, 0};  dt[3] = '{4, 0, 1};
      dt[4] = '{5, 0, 1};  dt[5] = '{6, 0, 1};  dt[6] = '{7, 1, 1};  dt[7] = '{8, 0, 2};

      st[0] = '{0,  0, 12'hFFF, 0, 12'h000, 0, 0};
      st[1] = '{2,  1, 12'hABC, 0, 12'h000, 0, 0};
      st[2] = '{3,  1, 12'hABC, 0, 12'h000, 1, 0};
      st[3] = '{4,  3, 12'hFFF, 0, 12'h000, 1, 1};
      st[4] = '{5,  3, 12'h123, 1, 12'h123, 1, 1};
      st[5] = '{12, 6, 12'hF0F, 1, 12'hF0F, 1, 1};
      st[6] = '{13, 6, 12'hFFF, 0, 12'h000, 1, 1};
      st[7] = '{8,  7, 12'hFFF, 0, 12'h000, 1, 1};
      st[8] = '{1,  2, 12'h5A5, 0, 12'h000, 0, 1};
      st[9] = '{8,  5, 12'h5A5, 1, 12'h5A5, 1, 1};

      rst_n = 1'b0;
      rgb   = 12'hFFF;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");

      @(negedge clk);
      rst_n = 1'b1;
      pe_cnt = 0; hs_low = 0; first_low = 0; col_bad = 0; ft_cnt = 0; vis_cnt = 0; vs_low = 0;

      // One full default-timing line, plus the first two small frames.
      for (int k = 1; k <= 3203; k++) begin
         @(posedge clk);
         #1;
         if (k <= 8) begin
            check($sformatf("d_pix_en edge %0d", dt[k-1].edge_n), d_pix_en, dt[k-1].pix_en);
            check($sformatf("d_hCount edge %0d", dt[k-1].edge_n), d_hcount, dt[k-1].h);
         end
         if (k <= 3200 && d_pix_en) pe_cnt++;
         if (!d_hsync) begin
            hs_low++;
            if (first_low == 0) first_low = k;
         end
         if ({d_r, d_g, d_b} != 12'h000) col_bad++;
         if (k == 400) begin
            check("d_hCount at edge 400", d_hcount, 100);
            check("d_bright at hCount 100", d_bright, 0);
         end
         if (k == 3200) begin
            check("d_hCount after 800 pixels", d_hcount, 0);
            check("d_vCount after 800 pixels", d_vcount, 1);
         end
         if (k <= 2 * SFRAME) begin
            if (s_frame_tick) ft_cnt++;
            if (s_r == 4'hF) vis_cnt++;
         end
         if (k <= SFRAME && !s_vsync) vs_low++;
      end
      check("d_pix_en count per line", pe_cnt, 800);
      check("d_hSync low clks per line", hs_low, 96 * 4);
      check("d_hSync first low edge", first_low, 4);
      check("d_colour nonzero while dark", col_bad, 0);
      check("s_frame_tick count in two frames", ft_cnt, 2);
      check("s_visible clks in two frames", vis_cnt, 2 * (SHE - SHB + 1) * (SVE - SVB + 1) * SDIV);
      check("s_vSync low clks per frame", vs_low, SVS * SHT * SDIV);

      // Per-position vectors on the small raster.
      for (int i = 0; i < 10; i++) begin
         wait_pos(st[i].h, st[i].v);
         rgb = st[i].rgb;
         #1;
         check($sformatf("vec%0d bright", i), s_bright, st[i].bright);
         repeat (SDIV) @(posedge clk);
         #1;
         check($sformatf("vec%0d colour", i), {s_r, s_g, s_b}, st[i].colour);
         check($sformatf("vec%0d hSync", i), s_hsync, st[i].hs);
         check($sformatf("vec%0d vSync", i), s_vsync, st[i].vs);
      end

      // Asynchronous reset between edges, in the middle of the visible area.
      rgb = 12'hFFF;
      wait_pos(10, 4);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (k == SDIV - 1) check("s_hCount before first pix_en", s_hcount, 0);
         if (k == SDIV)     check("s_hCount after restart", s_hcount, 1);
         if (k == 3)        check("d_hCount before first pix_en", d_hcount, 0);
         if (k == 4)        check("d_hCount after restart", d_hcount, 1);
      end
      repeat (300) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_timing_gen.md
DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 The block SHALL provide parameter DIV, default 4, meaning system clocks per pixel (100 MHz -> 25 MHz pixel rate).
REQ-002 The block SHALL provide parameters H_TOTAL=800, H_SYNC=96, H_START=144, H_END=783, V_TOTAL=525, V_SYNC=2, V_START=35, V_END=514 as counter limits for 640x480@60.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rgb  input  12  pixel colour {R[3:0],G[3:0],B[3:0]}; a combinational function of hCount/vCount from the drawing block.
REQ-006 hCount  output  10  horizontal pixel counter, 0..H_TOTAL-1.
REQ-007 vCount  output  10  vertical line counter, 0..V_TOTAL-1.
REQ-008 bright  output  1  high while (hCount,vCount) lies in the visible area.
REQ-009 pix_en  output  1  one-clk pulse once every DIV clks; marks counter advance.
REQ-010 frame_tick  output  1  one-clk pulse per frame; the slow game clock-enable.
REQ-011 hSync, vSync  output  1 each  active-low sync pulses, pipeline-aligned with vga_r/g/b.
REQ-012 vga_r, vga_g, vga_b  output  4 each  registered colour to the DAC pins.

Function
REQ-013 A divider counter SHALL count 0..DIV-1 and wrap; pix_en SHALL be high in exactly the clk cycle where the divider equals DIV-1.
REQ-014 hCount SHALL increment only on pix_en; on pix_en with hCount==H_TOTAL-1 it SHALL wrap to 0.
REQ-015 vCount SHALL increment only on pix_en with hCount==H_TOTAL-1; at vCount==V_TOTAL-1 it SHALL wrap to 0 in that same cycle as hCount wraps.
REQ-016 bright SHALL be combinational: 1 iff H_START<=hCount<=H_END and V_START<=vCount<=V_END.
REQ-017 frame_tick SHALL pulse for exactly one clk, coincident with the pix_en that wraps both hCount and vCount to 0.
REQ-018 On pix_en the block SHALL register the stage-1 outputs: colour = bright ? rgb : 12'h000; hSync = ~(hCount<H_SYNC); vSync = ~(vCount<V_SYNC).
REQ-019 vga_r/g/b, hSync and vSync SHALL therefore lag hCount/vCount by exactly one pixel period (DIV clks), keeping colour and syncs mutually aligned.
REQ-020 Registered outputs SHALL hold their values between pix_en pulses.
REQ-021 The colour path SHALL never drive a non-zero value when the registered bright was 0, regardless of rgb.
REQ-022 Arithmetic SHALL be unsigned 10-bit; counters SHALL never reach H_TOTAL or V_TOTAL.

Reset
REQ-023 While rst_n=0, the block SHALL hold divider=0, hCount=0, vCount=0, pix_en=0, frame_tick=0, hSync=1, vSync=1, vga_r/g/b=0.
REQ-024 Reset assertion mid-frame SHALL take effect immediately without waiting for clk; no partial pulse SHALL follow.
REQ-025 After rst_n rises, the first pix_en SHALL occur on the DIV-th rising clk edge; hCount SHALL become 1 then.

Verification
REQ-026 Release reset, DIV=4 -> pix_en on clk edges 4,8,12...; hCount 0->1 at edge 4; after 800 pix_en hCount=0, vCount=1.
REQ-027 Run two full frames -> frame_tick pulses exactly once per 800*525*4=1,680,000 clks, each one clk wide; vCount never exceeds 524.
REQ-028 Scan one line -> registered hSync low for exactly 96 pixel periods starting one pixel after hCount=0; vSync low for exactly 2 lines (1600 pixel periods).
REQ-029 Drive rgb=12'hF00 constant -> vga_r=4'hF only for pixels with hCount 144..783, vCount 35..514 (one-pixel lag); otherwise vga_r/g/b=0; total visible pixels per frame = 307,200.
REQ-030 Assert rst_n=0 at hCount=400, vCount=200, between clk edges -> all outputs reach reset values before the next clk edge; counting restarts from 0 after release.
REQ-031 Drive rgb=12'hFFF while bright=0 at hCount=100 -> vga_r/g/b stay 0.
